compositor_video: RTL and testbench



---
 rtl/compositor_video.sv | 220 ++++++++++++++++++++++
 tb/tb_compositor_video.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/compositor_video.sv
// Pixel compositor: time-multiplexes the sprite/background ROM per pixel,
// picks the top-priority visible sprite and emits registered colour and syncs.
module compositor_video #(
  parameter int          LARGURA = 640,
  parameter int          ALTURA  = 480,
  parameter int          SPR_L   = 72,
  parameter int          SPR_A   = 84,
  parameter logic [2:0]  TRANSP  = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_tick,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        ativo,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  pos_x_jog,
  input  logic [9:0]  pos_y_jog,
  input  logic [9:0]  pos_x_op1,
  input  logic [9:0]  pos_y_op1,
  input  logic [9:0]  pos_x_op2,
  input  logic [9:0]  pos_y_op2,
  input  logic [9:0]  pos_x_op3,
  input  logic [9:0]  pos_y_op3,
  input  logic [3:0]  velocidade,
  input  logic [2:0]  dado_fundo,
  input  logic [2:0]  dado_carro,
  input  logic [2:0]  dado_oponente1,
  input  logic [2:0]  dado_oponente2,
  input  logic [2:0]  dado_oponente3,
  output logic [18:0] endereco,
  output logic [2:0]  cor,
  output logic        valido,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        erro_tick
);

  typedef enum logic [1:0] {OCIOSO, FUNDO, SPRITE} estado_t;

  estado_t     estado_q, estado_d;
  logic        tick_ok, frame_ini;
  logic        erro_q;
  logic [8:0]  rolagem_q, rolagem_d;
  logic [9:0]  soma_rol;
  logic [9:0]  pos_x_in [4];
  logic [9:0]  pos_y_in [4];
  logic [9:0]  sx_q [4];
  logic [9:0]  sy_q [4];

  // stage 1: captured pixel coordinates and syncs
  logic [9:0]  x_p1_q, y_p1_q;
  logic        ativo_p1_q, hs_p1_q, vs_p1_q;

  // stage 2: background sample and hit result
  logic [2:0]  fundo_p2_q;
  logic        hit_p2_q, hit_d;
  logic [1:0]  sel_p2_q, sel_d;

  // output stage
  logic [2:0]  cor_q, cor_d;
  logic        valido_q, hs_q, vs_q;

  logic [11:0] lin_t;
  logic [18:0] end_fundo, end_spr;
  logic [9:0]  dx, dy;
  logic [2:0]  dado_spr;

  function automatic logic dentro(input logic [9:0] p, input logic [9:0] s,
                                  input logic [10:0] tam);
    logic [10:0] pe, se;
    pe = {1'b0, p};
    se = {1'b0, s};
    return (se <= pe) && (pe < se + tam);
  endfunction

  assign tick_ok   = pixel_tick && (estado_q != FUNDO);
  assign frame_ini = tick_ok && (x == 10'd0) && (y == 10'd0);

  assign pos_x_in[0] = pos_x_jog;
  assign pos_y_in[0] = pos_y_jog;
  assign pos_x_in[1] = pos_x_op1;
  assign pos_y_in[1] = pos_y_op1;
  assign pos_x_in[2] = pos_x_op2;
  assign pos_y_in[2] = pos_y_op2;
  assign pos_x_in[3] = pos_x_op3;
  assign pos_y_in[3] = pos_y_op3;

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:  if (pixel_tick) estado_d = FUNDO;
      FUNDO:   estado_d = SPRITE;
      SPRITE:  estado_d = pixel_tick ? FUNDO : OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    soma_rol  = {1'b0, rolagem_q} + {6'd0, velocidade};
    rolagem_d = rolagem_q;
    if (soma_rol >= 10'(ALTURA)) rolagem_d = 9'(soma_rol - 10'(ALTURA));
    else                         rolagem_d = soma_rol[8:0];
  end

  // Coordinates may exceed ALTURA during blanking, hence repeated reduction.
  always_comb begin
    lin_t = 12'(y_p1_q) + 12'(ALTURA) - 12'(rolagem_q);
    for (int i = 0; i < 3; i++) begin
      if (lin_t >= 12'(ALTURA)) lin_t = lin_t - 12'(ALTURA);
    end
    end_fundo = 19'(lin_t) * 19'(LARGURA) + 19'(x_p1_q);
  end

  // Lowest index wins, so scan from op3 down to the player.
  always_comb begin
    hit_d = 1'b0;
    sel_d = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (dentro(x_p1_q, sx_q[i], 11'(SPR_L)) && dentro(y_p1_q, sy_q[i], 11'(SPR_A))) begin
        hit_d = 1'b1;
        sel_d = 2'(i);
      end
    end
  end

  always_comb begin
    dx      = x_p1_q - sx_q[sel_p2_q];
    dy      = y_p1_q - sy_q[sel_p2_q];
    end_spr = 19'(dy) * 19'(SPR_L) + 19'(dx);
  end

  always_comb begin
    endereco = 19'd0;
    case (estado_q)
      FUNDO:   endereco = end_fundo;
      SPRITE:  endereco = hit_p2_q ? end_spr : 19'd0;
      default: endereco = 19'd0;
    endcase
  end

  always_comb begin
    case (sel_p2_q)
      2'd0:    dado_spr = dado_carro;
      2'd1:    dado_spr = dado_oponente1;
      2'd2:    dado_spr = dado_oponente2;
      default: dado_spr = dado_oponente3;
    endcase
    cor_d = fundo_p2_q;
    if (!ativo_p1_q)                        cor_d = 3'b000;
    else if (hit_p2_q && dado_spr != TRANSP) cor_d = dado_spr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      erro_q    <= 1'b0;
      rolagem_q <= 9'd0;
      for (int i = 0; i < 4; i++) begin
        sx_q[i] <= 10'd0;
        sy_q[i] <= 10'd0;
      end
    end else begin
      estado_q <= estado_d;
      if (pixel_tick && estado_q == FUNDO) erro_q <= 1'b1;
      if (frame_ini) begin
        rolagem_q <= rolagem_d;
        for (int i = 0; i < 4; i++) begin
          sx_q[i] <= pos_x_in[i];
          sy_q[i] <= pos_y_in[i];
        end
      end
    end
  end

  // stage 1 capture on accepted tick
  always_ff @(posedge clk) begin
    if (tick_ok) begin
      x_p1_q     <= x;
      y_p1_q     <= y;
      ativo_p1_q <= ativo;
      hs_p1_q    <= hsync_in;
      vs_p1_q    <= vsync_in;
    end
  end

  // stage 2 capture at the end of FUNDO
  always_ff @(posedge clk) begin
    if (estado_q == FUNDO) begin
      fundo_p2_q <= dado_fundo;
      hit_p2_q   <= hit_d;
      sel_p2_q   <= sel_d;
    end
  end

  // output stage loads at the end of SPRITE
  always_ff @(posedge clk) begin
    if (rst) begin
      cor_q    <= 3'b000;
      valido_q <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else if (estado_q == SPRITE) begin
      cor_q    <= cor_d;
      valido_q <= 1'b1;
      hs_q     <= hs_p1_q;
      vs_q     <= vs_p1_q;
    end else begin
      valido_q <= 1'b0;
    end
  end

  assign cor       = cor_q;
  assign valido    = valido_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;
  assign erro_tick = erro_q;

endmodule

// File: tb/tb_compositor_video.sv
// Directed bench for compositor_video: address generation, scroll, sprite
// priority/transparency, blanking, tick spacing and reset behaviour.
module tb_compositor_video;

  logic        clk;
  logic        rst;
  logic        pixel_tick;
  logic [9:0]  x, y;
  logic        ativo, hsync_in, vsync_in;
  logic [9:0]  pos_x_jog, pos_y_jog, pos_x_op1, pos_y_op1;
  logic [9:0]  pos_x_op2, pos_y_op2, pos_x_op3, pos_y_op3;
  logic [3:0]  velocidade;
  logic [2:0]  dado_fundo, dado_carro, dado_oponente1, dado_oponente2, dado_oponente3;
  logic [18:0] endereco;
  logic [2:0]  cor;
  logic        valido, hsync_out, vsync_out, erro_tick;

  int checks = 0;
  int failures = 0;

  logic [18:0] af, as_;
  logic        vs1, vo, hso, vso;
  logic [2:0]  co;
  int          cnt;

  compositor_video dut (
    .clk(clk), .rst(rst), .pixel_tick(pixel_tick), .x(x), .y(y), .ativo(ativo),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pos_x_jog(pos_x_jog), .pos_y_jog(pos_y_jog),
    .pos_x_op1(pos_x_op1), .pos_y_op1(pos_y_op1),
    .pos_x_op2(pos_x_op2), .pos_y_op2(pos_y_op2),
    .pos_x_op3(pos_x_op3), .pos_y_op3(pos_y_op3),
    .velocidade(velocidade), .dado_fundo(dado_fundo), .dado_carro(dado_carro),
    .dado_oponente1(dado_oponente1), .dado_oponente2(dado_oponente2),
    .dado_oponente3(dado_oponente3), .endereco(endereco), .cor(cor),
    .valido(valido), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .erro_tick(erro_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted pixel: records FUNDO address, SPRITE address and the output.
  task automatic pix(input logic [9:0] px, input logic [9:0] py,
                     input logic a, input logic hs, input logic vs);
    x = px; y = py; ativo = a; hsync_in = hs; vsync_in = vs;
    pixel_tick = 1'b1;
    step();
    pixel_tick = 1'b0;
    af = endereco;
    step();
    as_ = endereco;
    vs1 = valido;
    step();
    co = cor; vo = valido; hso = hsync_out; vso = vsync_out;
  endtask

  initial begin
    rst = 1'b1; pixel_tick = 1'b0; x = '0; y = '0; ativo = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1; velocidade = 4'd0;
    pos_x_jog = 10'd1000; pos_y_jog = 10'd1000; pos_x_op1 = 10'd1000; pos_y_op1 = 10'd1000;
    pos_x_op2 = 10'd1000; pos_y_op2 = 10'd1000; pos_x_op3 = 10'd1000; pos_y_op3 = 10'd1000;
    dado_fundo = 3'b101; dado_carro = 3'b000; dado_oponente1 = 3'b000;
    dado_oponente2 = 3'b000; dado_oponente3 = 3'b000;
    step(); step();
    chk("rst_cor", cor, 0);
    chk("rst_valido", valido, 0);
    chk("rst_hsync", hsync_out, 1);
    chk("rst_vsync", vsync_out, 1);
    chk("rst_endereco", endereco, 0);
    chk("rst_erro", erro_tick, 0);
    rst = 1'b0;
    step();

    // Frame start with sprites parked off-screen, then background pixel
    pix(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    chk("fs0_fundo_addr", af, 0);
    pix(10'd5, 10'd2, 1'b1, 1'b1, 1'b1);
    chk("bg_fundo_addr", af, 1285);
    chk("bg_spr_addr", as_, 0);
    chk("bg_valido_early", vs1, 0);
    chk("bg_cor", co, 3'b101);
    chk("bg_valido", vo, 1);
    step();
    chk("bg_valido_pulse", valido, 0);

    // Scroll: 32 frames at 15 lines wraps back to 0
    velocidade = 4'd15;
    for (int i = 0; i < 32; i++) begin
      pix(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
      if (i == 0)  chk("scroll_first", af, 297600);
      if (i == 31) chk("scroll_wrap", af, 0);
    end
    velocidade = 4'd9;
    pix(10'd0, 10'd1, 1'b1, 1'b1, 1'b1);
    chk("scroll_midframe", af, 640);
    velocidade = 4'd7;
    pix(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    chk("scroll_7", af, 302720);

    // Sprites: player and op1 overlap, op2 elsewhere
    velocidade = 4'd0;
    pos_x_jog = 10'd100; pos_y_jog = 10'd100; pos_x_op1 = 10'd100; pos_y_op1 = 10'd100;
    pos_x_op2 = 10'd200; pos_y_op2 = 10'd300;
    pix(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    dado_fundo = 3'b011; dado_carro = 3'b000; dado_oponente1 = 3'b110; dado_oponente2 = 3'b100;
    pix(10'd171, 10'd183, 1'b1, 1'b1, 1'b1);
    chk("spr_fundo_addr", af, 112811);
    chk("spr_addr_corner", as_, 6047);
    chk("spr_transp_cor", co, 3'b011);
    dado_carro = 3'b010;
    pix(10'd171, 10'd183, 1'b1, 1'b1, 1'b1);
    chk("spr_jog_cor", co, 3'b010);
    pix(10'd172, 10'd183, 1'b1, 1'b1, 1'b1);
    chk("spr_right_edge_addr", as_, 0);
    chk("spr_right_edge_cor", co, 3'b011);
    pix(10'd171, 10'd184, 1'b1, 1'b1, 1'b1);
    chk("spr_bottom_edge_addr", as_, 0);
    pix(10'd201, 10'd301, 1'b1, 1'b1, 1'b1);
    chk("spr_op2_addr", as_, 73);
    chk("spr_op2_cor", co, 3'b100);

    // Blanking: colour forced to 0, syncs pass through
    dado_fundo = 3'b101;
    pix(10'd5, 10'd2, 1'b0, 1'b0, 1'b1);
    chk("blank_cor", co, 0);
    chk("blank_hsync", hso, 0);
    chk("blank_vsync", vso, 1);
    chk("blank_valido", vo, 1);
    pix(10'd5, 10'd2, 1'b1, 1'b1, 1'b0);
    chk("sync_hsync", hso, 1);
    chk("sync_vsync", vso, 0);
    chk("sync_cor", co, 3'b101);

    // Tick violation: back-to-back ticks on consecutive cycles
    chk("erro_before", erro_tick, 0);
    ativo = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    x = 10'd5; y = 10'd2; pixel_tick = 1'b1;
    step();
    x = 10'd6;
    step();
    pixel_tick = 1'b0;
    chk("erro_set", erro_tick, 1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cnt += int'(valido);
    end
    chk("erro_one_valido", cnt, 1);
    chk("erro_sticky", erro_tick, 1);
    chk("erro_cor", cor, 3'b101);

    // Reset while in SPRITE
    x = 10'd5; y = 10'd2; hsync_in = 1'b0; pixel_tick = 1'b1;
    step();
    pixel_tick = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rstmid_valido", valido, 0);
    chk("rstmid_cor", cor, 0);
    chk("rstmid_hsync", hsync_out, 1);
    chk("rstmid_vsync", vsync_out, 1);
    chk("rstmid_endereco", endereco, 0);
    chk("rstmid_erro", erro_tick, 0);

    // Reset together with a tick: tick ignored
    pixel_tick = 1'b1;
    step();
    pixel_tick = 1'b0;
    rst = 1'b0;
    chk("rsttick_endereco", endereco, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      cnt += int'(valido);
    end
    chk("rsttick_no_valido", cnt, 0);
    chk("rsttick_erro", erro_tick, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
